loader_access_arbiter: RTL and testbench
========================================

# loader_access_arbiter

Shares the single SPILoader flash-access port between two requesters: the bubble emulation core (port A) and the auxiliary image-directory/menu reader (port B). It latches each requester's access type and absolute position, drives the loader's ACCTYPE/ABSPOS/IMGNUM inputs, and tracks the loader's busy handshake with start and run timeouts. It enforces a minimum idle gap between accesses and returns a completion pulse to the granted requester. It sits between the emulation core and the SPILoader instance.

## Interface
- START_TO, 255: max MCLK cycles from issue to LDRBUSY rising.
- RUN_TO, 65535: max MCLK cycles LDRBUSY may stay high (16-bit counter).
- GAP, 4: MCLK cycles ACCTYPE is held at 3'b000 after each access (1..15).

- MCLK  in  1  master clock; all logic on rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- A_REQ  in  1  port A request, level; held until A_ACK.
- A_TYPE  in  3  port A access type; 3'b000 is invalid.
- A_POS  in  12  port A absolute position.
- A_ACK  out  1  one-cycle grant pulse to A.
- A_DONE  out  1  one-cycle completion pulse to A.
- B_REQ, B_TYPE, B_POS, B_ACK, B_DONE: same as the A ports, for port B.
- IMGSEL  in  3  image number from the selector switches.
- IMGNUM  out  3  image number to the loader, latched at grant.
- ACCTYPE  out  3  access type to the loader.
- ABSPOS  out  12  absolute position to the loader.
- LDRBUSY  in  1  loader busy; high while an access is running.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- ERR  out  1  sticky timeout flag; cleared only by reset.

## Operation
- FSM states: IDLE, WAITSTART, WAITRUN, RELEASE.
- A request is valid only when REQ=1 and TYPE≠000. Invalid requests are never granted and never acknowledged.
- Arbitration in IDLE, when at least one request is valid:
  - Single valid request: grant it.
  - Both valid: grant the port not granted last. The LAST flag resets to B, so A wins the first tie.
- On grant:
  - Latch TYPE→ACCTYPE, POS→ABSPOS, IMGSEL→IMGNUM.
  - Pulse the granted ACK.
  - Update LAST.
  - Clear the timeout counter.
  - Go to WAITSTART.
- WAITSTART:
  - LDRBUSY=1 → clear counter, go to WAITRUN.
  - Counter reaches START_TO → set ERR, go to RELEASE.
- WAITRUN:
  - LDRBUSY=0 → go to RELEASE.
  - Counter reaches RUN_TO → set ERR, go to RELEASE.
- RELEASE:
  - ACCTYPE=000 throughout. ABSPOS and IMGNUM keep their latched values.
  - After GAP cycles, pulse the granted DONE and go to IDLE.
- DONE is pulsed even after a timeout, so a requester never hangs. ERR indicates that the data is invalid.
- Counters saturate. They never wrap.

## Timing
- Reset values: ACCTYPE=000, ABSPOS=0, IMGNUM=000, all ACK/DONE=0, BUSY=0, ERR=0, LAST=B, state IDLE. Reset is asynchronous: mid-access, ACCTYPE drops to 000 immediately.
- Grant latency:
  - Request valid at IDLE edge T → ACK, ACCTYPE, ABSPOS, IMGNUM and BUSY all valid from T+1.
  - ACK lasts exactly one cycle.
- Requester obligations:
  - Hold REQ, TYPE and POS stable until it samples ACK.
  - Drop REQ in the cycle after ACK.
  - A REQ still high after that is treated as a new request.
- Timeouts:
  - LDRBUSY never rises → ERR at T+1+START_TO.
  - Gap is then GAP cycles, then DONE.
- Minimum access:
  - LDRBUSY high for one cycle at T+2 → WAITRUN at T+3.
  - LDRBUSY low at T+3 → RELEASE at T+4.
  - ACCTYPE=000 from T+4 through T+3+GAP.
  - DONE at T+4+GAP, in the same cycle as the return to IDLE with BUSY=0.
- Back-to-back:
  - A request valid in the DONE/IDLE cycle is granted with ACK on the next cycle.
  - Minimum ACCTYPE=000 gap between accesses is GAP+1 cycles.
- Simultaneous REQ rising with LDRBUSY activity in IDLE: LDRBUSY is ignored outside WAITSTART/WAITRUN.
- A requester's REQ edges while the other port is being served are only sampled in IDLE. Edges are never lost because REQ is a level.

## Test plan
- Reset, then A_REQ with A_TYPE=110, A_POS=1018, IMGSEL=3:
  - A_ACK at T+1.
  - ACCTYPE=110, ABSPOS=1018, IMGNUM=3.
  - Loader model asserts LDRBUSY for 500 cycles → A_DONE exactly GAP+1 cycles after LDRBUSY falls; ERR=0.
- A_REQ and B_REQ raised in the same cycle, with both held:
  - Grant order is A, B, A, B.
  - Each grant's ACK is preceded by ≥GAP+1 cycles of ACCTYPE=000.
- B_REQ with B_TYPE=000 held for 1000 cycles:
  - No B_ACK, BUSY stays 0.
  - A later valid A request is granted normally.
- Loader model never asserts LDRBUSY:
  - ERR rises START_TO cycles after ACK, and DONE follows.
  - ERR stays 1 through subsequent successful accesses until nRESET.
- Reset mid-access:
  - Assert nRESET low during WAITRUN.
  - ACCTYPE=000 and BUSY=0 without a clock edge.
  - After release, the next A request is granted with ACK at T+1.
- RUN_TO=100 with LDRBUSY stuck high:
  - ERR is set 100 cycles after LDRBUSY rose.
  - ACCTYPE=000, then DONE GAP cycles later.

Source files
------------

// File: rtl/loader_access_arbiter_if.sv
// Requester, loader and status signals of loader_access_arbiter, bundled for port hookup.
// The master side drives the requests and loader busy; the slave side is the arbiter.
interface loader_access_arbiter_if;
  logic        A_REQ;
  logic [2:0]  A_TYPE;
  logic [11:0] A_POS;
  logic        A_ACK;
  logic        A_DONE;
  logic        B_REQ;
  logic [2:0]  B_TYPE;
  logic [11:0] B_POS;
  logic        B_ACK;
  logic        B_DONE;
  logic [2:0]  IMGSEL;
  logic [2:0]  IMGNUM;
  logic [2:0]  ACCTYPE;
  logic [11:0] ABSPOS;
  logic        LDRBUSY;
  logic        BUSY;
  logic        ERR;

  modport master (
    output A_REQ, A_TYPE, A_POS, B_REQ, B_TYPE, B_POS, IMGSEL, LDRBUSY,
    input  A_ACK, A_DONE, B_ACK, B_DONE, IMGNUM, ACCTYPE, ABSPOS, BUSY, ERR
  );

  modport slave (
    input  A_REQ, A_TYPE, A_POS, B_REQ, B_TYPE, B_POS, IMGSEL, LDRBUSY,
    output A_ACK, A_DONE, B_ACK, B_DONE, IMGNUM, ACCTYPE, ABSPOS, BUSY, ERR
  );
endinterface

// File: rtl/loader_access_arbiter.sv
// Two-port arbiter in front of the SPILoader access port. Grants one requester at a time,
// drives the loader access type/position/image, tracks the busy handshake with timeouts and
// enforces an idle gap (ACCTYPE=000) before signalling completion.
module loader_access_arbiter #(
  parameter int unsigned START_TO = 255,
  parameter int unsigned RUN_TO   = 65535,
  parameter int unsigned GAP      = 4
) (
  input logic                    MCLK,
  input logic                    nRESET,
  loader_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWaitStart, StWaitRun, StRelease} state_e;

  state_e      state_q, state_d;
  logic [2:0]  acctype_q, acctype_d;
  logic [11:0] abspos_q, abspos_d;
  logic [2:0]  imgnum_q, imgnum_d;
  logic        ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic        done_a_q, done_a_d, done_b_q, done_b_d;
  logic        err_q, err_d;
  // 1 = port B was granted last; also identifies the owner of the running access.
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]  gap_q, gap_d;

  logic a_valid, b_valid, grant_a, grant_b;
  logic start_hit, run_hit, gap_hit;

  assign a_valid = bus.A_REQ && (bus.A_TYPE != 3'b000);
  assign b_valid = bus.B_REQ && (bus.B_TYPE != 3'b000);

  // Saturating increment: the timeout counter never wraps.
  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign start_hit = 32'(cnt_inc) >= START_TO;
  assign run_hit   = 32'(cnt_inc) >= RUN_TO;
  assign gap_hit   = (32'(gap_q) + 32'd1) >= GAP;

  // State register.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and arbitration.
  always_comb begin
    state_d = state_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (a_valid && b_valid) begin
          grant_a = last_q;
          grant_b = !last_q;
        end else begin
          grant_a = a_valid;
          grant_b = b_valid;
        end
        if (grant_a || grant_b) state_d = StWaitStart;
      end
      StWaitStart: begin
        if (bus.LDRBUSY)   state_d = StWaitRun;
        else if (start_hit) state_d = StRelease;
      end
      StWaitRun: begin
        if (!bus.LDRBUSY) state_d = StRelease;
        else if (run_hit) state_d = StRelease;
      end
      StRelease: begin
        if (gap_hit) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    acctype_d = acctype_q;
    abspos_d  = abspos_q;
    imgnum_d  = imgnum_q;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    done_a_d  = 1'b0;
    done_b_d  = 1'b0;
    err_d     = err_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    unique case (state_q)
      StIdle: begin
        if (grant_a) begin
          acctype_d = bus.A_TYPE;
          abspos_d  = bus.A_POS;
          imgnum_d  = bus.IMGSEL;
          ack_a_d   = 1'b1;
          last_d    = 1'b0;
          cnt_d     = '0;
        end else if (grant_b) begin
          acctype_d = bus.B_TYPE;
          abspos_d  = bus.B_POS;
          imgnum_d  = bus.IMGSEL;
          ack_b_d   = 1'b1;
          last_d    = 1'b1;
          cnt_d     = '0;
        end
      end
      StWaitStart: begin
        if (bus.LDRBUSY) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (start_hit) begin
            err_d     = 1'b1;
            acctype_d = 3'b000;
            gap_d     = '0;
          end
        end
      end
      StWaitRun: begin
        if (!bus.LDRBUSY) begin
          acctype_d = 3'b000;
          gap_d     = '0;
        end else begin
          cnt_d = cnt_inc;
          if (run_hit) begin
            err_d     = 1'b1;
            acctype_d = 3'b000;
            gap_d     = '0;
          end
        end
      end
      StRelease: begin
        gap_d = gap_q + 4'd1;
        // DONE goes out even after a timeout so the owner never hangs.
        if (gap_hit) begin
          done_a_d = !last_q;
          done_b_d = last_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; asynchronous reset drops ACCTYPE immediately.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      acctype_q <= 3'b000;
      abspos_q  <= '0;
      imgnum_q  <= 3'b000;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      done_a_q  <= 1'b0;
      done_b_q  <= 1'b0;
      err_q     <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      gap_q     <= '0;
    end else begin
      acctype_q <= acctype_d;
      abspos_q  <= abspos_d;
      imgnum_q  <= imgnum_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      done_a_q  <= done_a_d;
      done_b_q  <= done_b_d;
      err_q     <= err_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
    end
  end

  assign bus.ACCTYPE = acctype_q;
  assign bus.ABSPOS  = abspos_q;
  assign bus.IMGNUM  = imgnum_q;
  assign bus.A_ACK   = ack_a_q;
  assign bus.B_ACK   = ack_b_q;
  assign bus.A_DONE  = done_a_q;
  assign bus.B_DONE  = done_b_q;
  assign bus.ERR     = err_q;
  assign bus.BUSY    = (state_q != StIdle);

endmodule

// File: tb/tb_loader_access_arbiter.sv
// Directed bench for loader_access_arbiter: a default instance with a small loader model, and
// a second instance with a short run timeout driven by hand.
module tb_loader_access_arbiter;
  localparam int unsigned START_TO = 255;
  localparam int unsigned GAP      = 4;
  localparam int unsigned RUN_TO_S = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  loader_access_arbiter_if ifm ();
  loader_access_arbiter_if ifr ();

  loader_access_arbiter #(
    .START_TO(START_TO),
    .RUN_TO  (65535),
    .GAP     (GAP)
  ) u_dut (
    .MCLK  (clk),
    .nRESET(rst_n),
    .bus   (ifm.slave)
  );

  loader_access_arbiter #(
    .START_TO(START_TO),
    .RUN_TO  (RUN_TO_S),
    .GAP     (GAP)
  ) u_dut_rt (
    .MCLK  (clk),
    .nRESET(rst_n),
    .bus   (ifr.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  // Loader model busy length after each ACK; 0 means the loader never responds.
  int ldr_len = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_done(input bit port_b, input int limit, output int n);
    n = 0;
    while (((port_b ? ifm.B_DONE : ifm.A_DONE) !== 1'b1) && n < limit) begin
      tick();
      n++;
    end
    check("done_seen", 32'(n < limit), 1);
  endtask

  // Loader model: raise LDRBUSY in the ACK cycle and hold it ldr_len cycles.
  initial begin : loader_model
    ifm.LDRBUSY = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ldr_len != 0 && (ifm.A_ACK === 1'b1 || ifm.B_ACK === 1'b1)) begin
        ifm.LDRBUSY = 1'b1;
        repeat (ldr_len) begin
          @(posedge clk);
          #1;
        end
        ifm.LDRBUSY = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    int fall;
    int k;
    int grants;
    int zrun;
    bit saw_ack;
    bit saw_busy;

    ifm.A_REQ = 0; ifm.A_TYPE = 0; ifm.A_POS = 0;
    ifm.B_REQ = 0; ifm.B_TYPE = 0; ifm.B_POS = 0; ifm.IMGSEL = 0;
    ifr.A_REQ = 0; ifr.A_TYPE = 0; ifr.A_POS = 0;
    ifr.B_REQ = 0; ifr.B_TYPE = 0; ifr.B_POS = 0; ifr.IMGSEL = 0; ifr.LDRBUSY = 0;

    // Reset values
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_acctype", 32'(ifm.ACCTYPE), 0);
    check("rst_abspos", 32'(ifm.ABSPOS), 0);
    check("rst_imgnum", 32'(ifm.IMGNUM), 0);
    check("rst_busy", 32'(ifm.BUSY), 0);
    check("rst_err", 32'(ifm.ERR), 0);
    check("rst_acks", 32'({ifm.A_ACK, ifm.B_ACK, ifm.A_DONE, ifm.B_DONE}), 0);
    rst_n = 1'b1;
    tick();

    // Basic access, loader busy for 500 cycles
    ldr_len = 500;
    ifm.A_REQ = 1; ifm.A_TYPE = 3'b110; ifm.A_POS = 12'd1018; ifm.IMGSEL = 3'd3;
    tick();
    check("t1_ack", 32'(ifm.A_ACK), 1);
    check("t1_acctype", 32'(ifm.ACCTYPE), 6);
    check("t1_abspos", 32'(ifm.ABSPOS), 1018);
    check("t1_imgnum", 32'(ifm.IMGNUM), 3);
    check("t1_busy", 32'(ifm.BUSY), 1);
    ifm.A_REQ = 0;
    tick();
    check("t1_ack_one_cycle", 32'(ifm.A_ACK), 0);
    n = 0;
    while (ifm.LDRBUSY !== 1'b0 && n < 1000) begin
      tick();
      n++;
    end
    check("t1_ldr_fall", 32'(n < 1000), 1);
    fall = cyc;
    wait_done(0, 50, n);
    check("t1_done_gap", 32'(cyc - fall), GAP + 1);
    check("t1_err", 32'(ifm.ERR), 0);
    check("t1_done_idle", 32'({ifm.BUSY, ifm.ACCTYPE}), 0);
    check("t1_abspos_kept", 32'(ifm.ABSPOS), 1018);

    // Tie arbitration from a fresh LAST=B
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    ldr_len = 3;
    ifm.A_REQ = 1; ifm.A_TYPE = 3'd1; ifm.A_POS = 12'd10;
    ifm.B_REQ = 1; ifm.B_TYPE = 3'd2; ifm.B_POS = 12'd20;
    grants = 0;
    zrun = 0;
    for (int i = 0; i < 400 && grants < 4; i++) begin
      tick();
      if (ifm.A_ACK === 1'b1 || ifm.B_ACK === 1'b1) begin
        check($sformatf("t2_grant%0d_is_b", grants), 32'(ifm.B_ACK), 32'(grants % 2));
        check($sformatf("t2_grant%0d_type", grants), 32'(ifm.ACCTYPE),
              (grants % 2 == 1) ? 2 : 1);
        if (grants > 0) check($sformatf("t2_gap%0d", grants), 32'(zrun >= int'(GAP) + 1), 1);
        grants++;
      end
      zrun = (ifm.ACCTYPE == 3'b000) ? zrun + 1 : 0;
    end
    check("t2_grant_count", 32'(grants), 4);
    ifm.A_REQ = 0; ifm.B_REQ = 0;
    wait_done(1, 50, n);

    // Invalid type on B is never granted
    ifm.B_REQ = 1; ifm.B_TYPE = 3'b000; ifm.B_POS = 12'd5;
    saw_ack = 0;
    saw_busy = 0;
    repeat (1000) begin
      tick();
      if (ifm.B_ACK === 1'b1) saw_ack = 1;
      if (ifm.BUSY !== 1'b0) saw_busy = 1;
    end
    check("t3_no_b_ack", 32'(saw_ack), 0);
    check("t3_no_busy", 32'(saw_busy), 0);
    ifm.A_REQ = 1; ifm.A_TYPE = 3'd3; ifm.A_POS = 12'd7; ifm.IMGSEL = 3'd5;
    tick();
    check("t3_a_ack", 32'({ifm.A_ACK, ifm.B_ACK}), 2);
    check("t3_acctype", 32'(ifm.ACCTYPE), 3);
    check("t3_imgnum", 32'(ifm.IMGNUM), 5);
    ifm.A_REQ = 0;
    wait_done(0, 50, n);
    ifm.B_REQ = 0;

    // Start timeout: loader never responds
    ldr_len = 0;
    ifm.A_REQ = 1; ifm.A_TYPE = 3'd2; ifm.A_POS = 12'd100;
    tick();
    check("t4_ack", 32'(ifm.A_ACK), 1);
    ifm.A_REQ = 0;
    k = cyc;
    repeat (START_TO - 1) tick();
    check("t4_err_before", 32'(ifm.ERR), 0);
    tick();
    check("t4_err_at_to", 32'(ifm.ERR), 1);
    check("t4_err_cycle", 32'(cyc - k), START_TO);
    check("t4_acctype_zero", 32'(ifm.ACCTYPE), 0);
    repeat (GAP - 1) tick();
    check("t4_done_early", 32'(ifm.A_DONE), 0);
    tick();
    check("t4_done", 32'(ifm.A_DONE), 1);
    check("t4_idle", 32'(ifm.BUSY), 0);
    ldr_len = 3;
    ifm.A_REQ = 1; ifm.A_TYPE = 3'd4; ifm.A_POS = 12'd200;
    tick();
    check("t4_next_ack", 32'(ifm.A_ACK), 1);
    ifm.A_REQ = 0;
    wait_done(0, 50, n);
    check("t4_err_sticky", 32'(ifm.ERR), 1);

    // Reset in the middle of an access
    ldr_len = 300;
    ifm.A_REQ = 1; ifm.A_TYPE = 3'd5; ifm.A_POS = 12'd33; ifm.IMGSEL = 3'd2;
    tick();
    check("t5_ack", 32'(ifm.A_ACK), 1);
    ifm.A_REQ = 0;
    repeat (10) tick();
    check("t5_running", 32'({ifm.BUSY, ifm.ACCTYPE}), 32'({1'b1, 3'd5}));
    rst_n = 1'b0;
    #1;
    check("t5_rst_acctype", 32'(ifm.ACCTYPE), 0);
    check("t5_rst_busy", 32'(ifm.BUSY), 0);
    check("t5_rst_err", 32'(ifm.ERR), 0);
    tick();
    rst_n = 1'b1;
    ldr_len = 3;
    ifm.A_REQ = 1; ifm.A_TYPE = 3'd1; ifm.A_POS = 12'd9;
    tick();
    check("t5_regrant_ack", 32'(ifm.A_ACK), 1);
    check("t5_regrant_type", 32'(ifm.ACCTYPE), 1);
    ifm.A_REQ = 0;
    wait_done(0, 600, n);
    check("t5_err_clear", 32'(ifm.ERR), 0);

    // Run timeout on the short-RUN_TO instance: LDRBUSY stuck high
    ifr.A_REQ = 1; ifr.A_TYPE = 3'd5; ifr.A_POS = 12'd77;
    tick();
    check("t6_ack", 32'(ifr.A_ACK), 1);
    ifr.A_REQ = 0;
    ifr.LDRBUSY = 1;
    repeat (RUN_TO_S) tick();
    check("t6_err_before", 32'(ifr.ERR), 0);
    tick();
    check("t6_err", 32'(ifr.ERR), 1);
    check("t6_acctype_zero", 32'(ifr.ACCTYPE), 0);
    repeat (GAP - 1) tick();
    check("t6_done_early", 32'(ifr.A_DONE), 0);
    tick();
    check("t6_done", 32'(ifr.A_DONE), 1);
    ifr.LDRBUSY = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
